// File: rtl/memory_adaptor.sv
// Byte-wide RAM/IO bus arbiter: serves 32-bit instruction fetches and byte/half/word
// data loads/stores one byte per cycle, little-endian, with a pending slot per requester.
module memory_adaptor #(
  parameter logic [31:0] IO_ADDR_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        request_ins_from_memory_adaptor,
  input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
  output logic [31:0] ins_fetched_from_memory_adaptor,
  output logic        insfetch_task_done,
  input  logic        data_request,
  input  logic        data_is_write,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_task_done,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

  state_t      r_state;
  logic [1:0]  r_cnt, r_last;
  logic        r_is_ins, r_io, r_wr_en;
  logic [31:0] r_buf, r_mem_a, r_ins_word, r_data_word;
  logic [23:0] r_wshift;
  logic [7:0]  r_mem_dout;
  logic        r_ins_done, r_data_done;
  logic        r_ins_pend, r_dat_pend, r_dat_we;
  logic [31:0] r_ins_addr, r_dat_addr, r_dat_wdata;
  logic [1:0]  r_dat_size;

  logic        w_ins_v, w_dat_v, w_dat_keep, w_dat_we, w_mem_wr;
  logic [31:0] w_ins_addr, w_dat_addr, w_dat_wdata, w_buf_next;
  logic [1:0]  w_dat_size;

  function automatic logic [1:0] last_cnt(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // A request arriving in the same cycle is served without a trip through its slot;
  // a coincident flush drops reads but lets writes through.
  assign w_dat_keep  = data_request & (data_is_write | ~flush_pipline);
  assign w_dat_v     = data_request ? w_dat_keep : (r_dat_pend & (r_dat_we | ~flush_pipline));
  assign w_dat_we    = data_request ? data_is_write : r_dat_we;
  assign w_dat_size  = data_request ? data_size : r_dat_size;
  assign w_dat_addr  = data_request ? data_addr : r_dat_addr;
  assign w_dat_wdata = data_request ? data_wdata : r_dat_wdata;
  assign w_ins_v     = ~flush_pipline & (request_ins_from_memory_adaptor | r_ins_pend);
  assign w_ins_addr  = request_ins_from_memory_adaptor ?
                       insaddr_to_be_fetched_from_memory_adaptor : r_ins_addr;

  assign w_mem_wr = r_wr_en & rdy_in & ~(r_io & io_buffer_full);

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_cnt, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_last      <= 2'd0;
      r_is_ins    <= 1'b0;
      r_io        <= 1'b0;
      r_wr_en     <= 1'b0;
      r_buf       <= 32'd0;
      r_mem_a     <= 32'd0;
      r_ins_word  <= 32'd0;
      r_data_word <= 32'd0;
      r_wshift    <= 24'd0;
      r_mem_dout  <= 8'd0;
      r_ins_done  <= 1'b0;
      r_data_done <= 1'b0;
      r_ins_pend  <= 1'b0;
      r_dat_pend  <= 1'b0;
      r_dat_we    <= 1'b0;
      r_ins_addr  <= 32'd0;
      r_dat_addr  <= 32'd0;
      r_dat_wdata <= 32'd0;
      r_dat_size  <= 2'd0;
    end else if (rdy_in) begin
      r_ins_done  <= 1'b0;
      r_data_done <= 1'b0;

      if (data_request) begin
        r_dat_pend  <= w_dat_keep;
        r_dat_we    <= data_is_write;
        r_dat_size  <= data_size;
        r_dat_addr  <= data_addr;
        r_dat_wdata <= data_wdata;
      end else if (flush_pipline && !r_dat_we) begin
        r_dat_pend <= 1'b0;
      end

      if (request_ins_from_memory_adaptor) begin
        r_ins_pend <= ~flush_pipline;
        r_ins_addr <= insaddr_to_be_fetched_from_memory_adaptor;
      end else if (flush_pipline) begin
        r_ins_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_dat_v) begin
            r_dat_pend <= 1'b0;
            r_mem_a    <= w_dat_addr;
            r_cnt      <= 2'd0;
            r_buf      <= 32'd0;
            r_last     <= last_cnt(w_dat_size);
            r_is_ins   <= 1'b0;
            if (w_dat_we) begin
              r_state    <= S_WRITE;
              r_wr_en    <= 1'b1;
              r_mem_dout <= w_dat_wdata[7:0];
              r_wshift   <= w_dat_wdata[31:8];
              r_io       <= (w_dat_addr >= IO_ADDR_BASE);
            end else begin
              r_state <= S_READ;
            end
          end else if (w_ins_v) begin
            r_ins_pend <= 1'b0;
            r_mem_a    <= w_ins_addr;
            r_cnt      <= 2'd0;
            r_buf      <= 32'd0;
            r_last     <= 2'd3;
            r_is_ins   <= 1'b1;
            r_state    <= S_READ;
          end
        end

        S_READ: begin
          if (flush_pipline) begin
            r_state <= S_IDLE;
          end else begin
            r_buf <= w_buf_next;
            if (r_cnt == r_last) begin
              r_state <= S_IDLE;
              if (r_is_ins) begin
                r_ins_word <= w_buf_next;
                r_ins_done <= 1'b1;
              end else begin
                r_data_word <= w_buf_next;
                r_data_done <= 1'b1;
              end
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_mem_a <= r_mem_a + 32'd1;
            end
          end
        end

        S_WRITE: begin
          // The counter only advances on cycles where a byte actually left on the bus.
          if (w_mem_wr) begin
            if (r_cnt == r_last) begin
              r_wr_en     <= 1'b0;
              r_data_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cnt      <= r_cnt + 2'd1;
              r_mem_a    <= r_mem_a + 32'd1;
              r_mem_dout <= r_wshift[7:0];
              r_wshift   <= {8'd0, r_wshift[23:8]};
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_a                           = r_mem_a;
  assign mem_dout                        = r_mem_dout;
  assign mem_wr                          = w_mem_wr;
  assign ins_fetched_from_memory_adaptor = r_ins_word;
  assign insfetch_task_done              = r_ins_done;
  assign data_rdata                      = r_data_word;
  assign data_task_done                  = r_data_done;
  assign o_dbg_state                     = r_state;

endmodule

// File: tb/tb_memory_adaptor.sv
// Scoreboard bench for memory_adaptor: drivers push expected done pulses and bus writes
// (with their cycle numbers) into queues; a negedge monitor pops and compares.
module tb_memory_adaptor;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_full = 1'b0;
  logic        ins_req = 1'b0;
  logic [31:0] ins_addr = 32'd0, ins_word;
  logic        ins_done;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0, d_rdata;
  logic        d_done;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  ram [0:255];
  logic [63:0] ins_q[$];   // {cycle, word}
  logic [64:0] dat_q[$];   // {check_word, cycle, word}
  logic [71:0] wr_q[$];    // {cycle, addr, byte}

  memory_adaptor dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_pipline(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full),
    .request_ins_from_memory_adaptor(ins_req),
    .insaddr_to_be_fetched_from_memory_adaptor(ins_addr),
    .ins_fetched_from_memory_adaptor(ins_word),
    .insfetch_task_done(ins_done),
    .data_request(d_req), .data_is_write(d_we), .data_size(d_size),
    .data_addr(d_addr), .data_wdata(d_wdata), .data_rdata(d_rdata),
    .data_task_done(d_done), .o_dbg_state(dbg_state)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_din = ram[mem_a[7:0]];
  always @(posedge clk) if (mem_wr && mem_a < 32'h0003_0000) ram[mem_a[7:0]] <= mem_dout;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] b);
    wr_q.push_back({c[31:0], a, b});
  endtask

  task automatic drive_data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  task automatic release_reqs();
    d_req = 1'b0; ins_req = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [63:0] ei;
    logic [64:0] ed;
    logic [71:0] ew;
    if (!rst) begin
      if (ins_done && d_done) begin
        n_vec++; n_err++;
        $display("FAIL both_done: both done pulses high (cycle %0d)", cyc);
      end
      if (ins_done) begin
        n_vec++;
        if (ins_q.size() == 0) begin
          n_err++;
          $display("FAIL ins_done_unexpected: word %h at cycle %0d, none expected", ins_word, cyc);
        end else begin
          ei = ins_q.pop_front();
          if (cyc != int'(ei[63:32]) || ins_word !== ei[31:0]) begin
            n_err++;
            $display("FAIL ins_done: got %h at cycle %0d expected %h at cycle %0d",
                     ins_word, cyc, ei[31:0], ei[63:32]);
          end
        end
      end
      if (d_done) begin
        n_vec++;
        if (dat_q.size() == 0) begin
          n_err++;
          $display("FAIL data_done_unexpected: rdata %h at cycle %0d", d_rdata, cyc);
        end else begin
          ed = dat_q.pop_front();
          if (cyc != int'(ed[63:32]) || (ed[64] && d_rdata !== ed[31:0])) begin
            n_err++;
            $display("FAIL data_done: got %h at cycle %0d expected %h at cycle %0d",
                     d_rdata, cyc, ed[31:0], ed[63:32]);
          end
        end
      end
      if (mem_wr) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_wr_unexpected: addr %h byte %h at cycle %0d", mem_a, mem_dout, cyc);
        end else begin
          ew = wr_q.pop_front();
          if (cyc != int'(ew[71:40]) || mem_a !== ew[39:8] || mem_dout !== ew[7:0]) begin
            n_err++;
            $display("FAIL mem_wr: got %h<=%h at cycle %0d expected %h<=%h at cycle %0d",
                     mem_a, mem_dout, cyc, ew[39:8], ew[7:0], ew[71:40]);
          end
        end
      end
    end
  end

  // driver
  initial begin
    int c0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    {ram[3], ram[2], ram[1], ram[0]}     = 32'h00A0_0513;
    {ram[7], ram[6], ram[5], ram[4]}     = 32'h0010_0093;
    {ram[9], ram[8]}                     = 16'h1234;
    {ram[15], ram[14], ram[13], ram[12]} = 32'h1234_5678;
    ram[255] = 8'hAB;

    tick(3);
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("reset_dones", {30'd0, ins_done, d_done}, 32'd0);
    check("reset_words", ins_word | d_rdata, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick(2);

    // word fetch
    c0 = cyc; ins_q.push_back({32'(c0 + 5), 32'h00A0_0513});
    ins_req = 1'b1; ins_addr = 32'h100; tick(1); release_reqs(); tick(8);

    // word store
    c0 = cyc;
    push_wr(c0 + 1, 32'h20, 8'hEF); push_wr(c0 + 2, 32'h21, 8'hBE);
    push_wr(c0 + 3, 32'h22, 8'hAD); push_wr(c0 + 4, 32'h23, 8'hDE);
    dat_q.push_back({1'b0, 32'(c0 + 5), 32'd0});
    drive_data(1'b1, 2'b10, 32'h20, 32'hDEAD_BEEF); tick(1); release_reqs(); tick(8);
    check("store_readback", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'hDEAD_BEEF);

    // IO byte store with sink full for three cycles
    c0 = cyc;
    push_wr(c0 + 4, 32'h0003_0000, 8'h41);
    dat_q.push_back({1'b0, 32'(c0 + 5), 32'd0});
    drive_data(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041); tick(1); release_reqs();
    io_full = 1'b1; tick(3); io_full = 1'b0; tick(6);

    // simultaneous fetch and half load: data first
    c0 = cyc;
    dat_q.push_back({1'b1, 32'(c0 + 3), 32'h0000_1234});
    ins_q.push_back({32'(c0 + 8), 32'h00A0_0513});
    drive_data(1'b0, 2'b01, 32'h8, 32'd0); ins_req = 1'b1; ins_addr = 32'h100;
    tick(1); release_reqs(); tick(10);

    // flush aborts a fetch; follow-up fetch completes
    c0 = cyc;
    ins_req = 1'b1; ins_addr = 32'h100; tick(1); release_reqs();
    tick(2); flush = 1'b1; tick(1); flush = 1'b0;
    check("flush_idle", {30'd0, dbg_state}, 32'd0);
    ins_q.push_back({32'(c0 + 9), 32'h0010_0093});
    ins_req = 1'b1; ins_addr = 32'h104; tick(1); release_reqs(); tick(8);

    // word load stalled by rdy low in C2..C4
    c0 = cyc;
    dat_q.push_back({1'b1, 32'(c0 + 8), 32'h1234_5678});
    drive_data(1'b0, 2'b10, 32'hC, 32'd0); tick(1); release_reqs();
    tick(1); rdy = 1'b0; tick(3); rdy = 1'b1; tick(8);

    // half load wrapping past 0xFFFFFFFF
    c0 = cyc;
    dat_q.push_back({1'b1, 32'(c0 + 3), 32'h0000_13AB});
    drive_data(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0); tick(1); release_reqs(); tick(6);

    // half store, then illegal size treated as word
    c0 = cyc;
    push_wr(c0 + 1, 32'h40, 8'hBE); push_wr(c0 + 2, 32'h41, 8'hBA);
    dat_q.push_back({1'b0, 32'(c0 + 3), 32'd0});
    drive_data(1'b1, 2'b01, 32'h40, 32'hCAFE_BABE); tick(1); release_reqs(); tick(5);
    c0 = cyc;
    push_wr(c0 + 1, 32'h50, 8'h04); push_wr(c0 + 2, 32'h51, 8'h03);
    push_wr(c0 + 3, 32'h52, 8'h02); push_wr(c0 + 4, 32'h53, 8'h01);
    dat_q.push_back({1'b0, 32'(c0 + 5), 32'd0});
    drive_data(1'b1, 2'b11, 32'h50, 32'h0102_0304); tick(1); release_reqs(); tick(7);

    // reset asserted mid-write
    c0 = cyc;
    push_wr(c0 + 1, 32'h24, 8'h44); push_wr(c0 + 2, 32'h25, 8'h33);
    drive_data(1'b1, 2'b10, 32'h24, 32'h1122_3344); tick(1); release_reqs(); tick(2);
    rst = 1'b1; #1;
    check("reset_mid_write_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mid_write_state", {30'd0, dbg_state}, 32'd0);
    tick(2); rst = 1'b0; tick(6);

    // anything still queued never arrived within its budget
    while (ins_q.size() > 0) begin
      void'(ins_q.pop_front()); n_vec++; n_err++;
      $display("FAIL ins_done_missing: expected fetch done never seen");
    end
    while (dat_q.size() > 0) begin
      void'(dat_q.pop_front()); n_vec++; n_err++;
      $display("FAIL data_done_missing: expected data done never seen");
    end
    while (wr_q.size() > 0) begin
      void'(wr_q.pop_front()); n_vec++; n_err++;
      $display("FAIL mem_wr_missing: expected bus write never seen");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
